sysbus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single Sysbus port between NUM_MASTERS requesters: instruction fetcher, data-memory engine, and later a page-table walker.
- Owns the bus from request grant through the last response beat, then hands it to the next requester.
- Sits between the fetch/data-memory blocks and the top-level bus pins.
- Replaces the fixed-priority I/D arbiter.

---
 rtl/sysbus_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_sysbus_rr_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: round-robin owner of the single Sysbus port, held from grant through the last beat.
// Optional watchdog abort enabled by defining SYSBUS_ARB_TIMEOUT_EN.
module sysbus_rr_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_MASTERS    = 3,
  parameter int BEATS_PER_LINE = 8,
  parameter int WR_TAG_BIT     = 12,
  parameter int WR_TAG_VAL     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                m_reqcyc,
  input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_req,
  input  logic [NUM_MASTERS*BUS_TAG_WIDTH-1:0]  m_reqtag,
  output logic [NUM_MASTERS-1:0]                m_reqack,
  output logic [NUM_MASTERS-1:0]                m_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]             m_resp,
  output logic [BUS_TAG_WIDTH-1:0]              m_resptag,
  input  logic [NUM_MASTERS-1:0]                m_respack,
  output logic                                  bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]             bus_req,
  output logic [BUS_TAG_WIDTH-1:0]              bus_reqtag,
  input  logic                                  bus_reqack,
  input  logic                                  bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]             bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]              bus_resptag,
  output logic                                  bus_respack,
  output logic [1:0]                            owner,
  output logic                                  busy,
  output logic                                  err_timeout
);
  localparam int CW = BEATS_PER_LINE > 1 ? $clog2(BEATS_PER_LINE) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;
  state_t state, state_n;
  logic [1:0] owner_n, rr_ptr, rr_n, gnt, nxt;
  logic gnt_ok, req_hs, resp_hs, last, timeout, xfer;
  logic [CW-1:0] cnt, cnt_n;
  logic [2*NUM_MASTERS-1:0] rot;
  logic [BUS_DATA_WIDTH-1:0] req_arr [NUM_MASTERS];
  logic [BUS_TAG_WIDTH-1:0] tag_arr [NUM_MASTERS];
  genvar g;
  for (g = 0; g < NUM_MASTERS; g++) begin : g_split
    assign req_arr[g] = m_req[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign tag_arr[g] = m_reqtag[g*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
  end
  assign req_hs  = bus_reqcyc && bus_reqack;
  assign resp_hs = bus_respcyc && bus_respack;
  assign last    = cnt == CW'(BEATS_PER_LINE - 1);
  assign nxt     = owner == 2'(NUM_MASTERS - 1) ? 2'd0 : owner + 2'd1;
  // Rotate requests so the search always starts at bit 0; scan downward so the lowest hit wins.
  assign rot = {m_reqcyc, m_reqcyc} >> rr_ptr;
  always_comb begin
    gnt_ok = 1'b0;
    gnt = 2'd0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (rot[i]) begin
        gnt_ok = 1'b1;
        gnt = ({1'b0, rr_ptr} + 3'(i) >= 3'(NUM_MASTERS)) ? 2'({1'b0, rr_ptr} + 3'(i) - 3'(NUM_MASTERS)) : rr_ptr + 2'(i);
      end
  end
`ifdef SYSBUS_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic to_q;
  assign timeout = state != IDLE && !req_hs && !resp_hs && wd == WW'(TIMEOUT_CYCLES - 1);
  assign err_timeout = to_q;
  always_ff @(posedge clk)
    if (!reset) begin
      wd <= '0;
      to_q <= 1'b0;
    end else begin
      wd <= (state == IDLE || req_hs || resp_hs || timeout) ? '0 : wd + 1'b1;
      to_q <= timeout;
    end
`else
  assign timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      owner <= 2'd0;
      rr_ptr <= 2'd0;
      cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n = rr_ptr;
    cnt_n = cnt;
    case (state)
      IDLE: if (gnt_ok) begin
        state_n = REQ;
        owner_n = gnt;
      end
      REQ: if (!m_reqcyc[owner]) begin
        state_n = IDLE;
        rr_n = nxt;
      end else if (req_hs) begin
        state_n = bus_reqtag[WR_TAG_BIT] == 1'(WR_TAG_VAL) ? WDATA : RESP;
        cnt_n = '0;
      end
      WDATA: if (req_hs) begin
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? IDLE : WDATA;
        rr_n = last ? nxt : rr_ptr;
      end
      RESP: if (resp_hs) begin
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? IDLE : RESP;
        rr_n = last ? nxt : rr_ptr;
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      rr_n = nxt;
      cnt_n = '0;
    end
  end
  always_comb begin
    busy = state != IDLE;
    xfer = state == REQ || state == WDATA;
    bus_reqcyc = xfer && m_reqcyc[owner];
    bus_req = xfer ? req_arr[owner] : '0;
    bus_reqtag = xfer ? tag_arr[owner] : '0;
    m_reqack = '0;
    m_reqack[owner] = xfer && bus_reqack;
    m_respcyc = '0;
    m_respcyc[owner] = state == RESP && bus_respcyc;
    bus_respack = state == RESP && m_respack[owner];
    m_resp = state == RESP ? bus_resp : '0;
    m_resptag = state == RESP ? bus_resptag : '0;
  end
endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// tb_sysbus_rr_arbiter: directed bench with scoreboards for grant order, response beats and write data.
module tb_sysbus_rr_arbiter;
  localparam int DW = 64, TW = 13, N = 3, B = 8;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] m_reqcyc = '0, m_reqack, m_respcyc, m_respack = '0;
  logic [N*DW-1:0] m_req = '0;
  logic [N*TW-1:0] m_reqtag = '0;
  logic [DW-1:0] m_resp, bus_req, bus_resp = '0;
  logic [TW-1:0] m_resptag, bus_reqtag, bus_resptag = '0;
  logic bus_reqcyc, bus_reqack = 1'b0, bus_respcyc = 1'b0, bus_respack, busy, err_timeout;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  logic [1:0] own_q[$];
  logic [N+TW+DW-1:0] resp_q[$];
  logic [DW-1:0] wr_q[$];

  sysbus_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
    .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .owner(owner), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Bus side of one read: wait for grant, ack the request, return B beats (optionally reset at beat abort_at).
  task automatic do_read(input int abort_at);
    logic [1:0] o;
    logic [N-1:0] oh;
    logic [N+TW+DW-1:0] e;
    bus_respcyc = 1'b0;
    for (int i = 0; i < 8 && busy !== 1'b1; i++) step();
    chk("grant_busy", busy, 1);
    o = own_q.pop_front();
    chk("grant_owner", owner, o);
    oh = 3'b001 << o;
    m_respack = oh;
    bus_reqack = 1'b1;
    #1;
    chk("req_fwd", {bus_reqcyc, m_reqack, bus_req}, {1'b1, oh, 64'hA000_0000 + 64'(o)});
    step();
    bus_reqack = 1'b0;
    for (int b = 0; b < B; b++) begin
      if (b == abort_at) reset = 1'b0;
      bus_respcyc = 1'b1;
      bus_resp = 64'hC0DE_0000 + 64'(o) * 16 + 64'(b);
      bus_resptag = 13'h1000 | 13'(b);
      resp_q.push_back({oh, bus_resptag, bus_resp});
      #1;
      e = resp_q.pop_front();
      chk("resp_beat", {m_respcyc, m_resptag, m_resp, bus_respack}, {e, 1'b1});
      step();
      if (b == abort_at) break;
    end
    bus_respcyc = 1'b0;
  endtask

  initial begin
    int pulses, bad, k;
    logic acked;
    for (int i = 0; i < N; i++) begin
      m_req[i*DW +: DW] = 64'hA000_0000 + 64'(i);
      m_reqtag[i*TW +: TW] = 13'h1000 | 13'(i);
    end
    repeat (3) step();
    chk("reset_ctrl", {m_reqack, m_respcyc, bus_reqcyc, bus_respack, owner, busy, err_timeout}, 0);
    chk("reset_bus", {bus_req, bus_reqtag}, 0);
    chk("reset_resp", {m_resp, m_resptag}, 0);
    reset = 1'b1;
    step();
    chk("post_reset", {m_reqack, m_respcyc, bus_reqcyc, bus_respack, owner, busy, err_timeout}, 0);

    // Two simultaneous reads; a stray response in IDLE must be ignored.
    m_reqcyc = 3'b011;
    bus_respcyc = 1'b1;
    #1;
    chk("idle_no_grant_yet", {bus_reqcyc, m_respcyc, bus_respack, busy}, 0);
    own_q.push_back(2'd0);
    own_q.push_back(2'd1);
    do_read(-1);
    chk("handoff_idle", {busy, bus_reqcyc}, 0);
    do_read(-1);
    m_reqcyc = 3'b000;
    chk("idle_after_pair", busy, 0);

    // Write from master 2: address phase plus B data beats, bus acks every other cycle.
    m_reqcyc = 3'b100;
    m_reqtag[2*TW +: TW] = 13'h0002;
    m_req[2*DW +: DW] = 64'hB000_0000;
    wr_q.push_back(64'hB000_0000);
    step();
    chk("wr_grant", {busy, owner}, {1'b1, 2'd2});
    pulses = 0;
    bad = 0;
    k = 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      bus_reqack = i[0];
      #1;
      acked = m_reqack[2];
      if (acked) begin
        pulses++;
        chk("wr_beat", bus_req, wr_q.pop_front());
        k++;
      end
      if (bus_respack || m_reqack[1:0] != 2'b00) bad++;
      step();
      if (acked && k <= B) begin
        m_req[2*DW +: DW] = 64'hD000_0000 + 64'(k - 1);
        wr_q.push_back(64'hD000_0000 + 64'(k - 1));
      end
    end
    m_reqcyc = 3'b000;
    bus_reqack = 1'b0;
    chk("wr_pulses", pulses, 9);
    chk("wr_no_resp", bad, 0);
    chk("wr_done_idle", busy, 0);
    chk("wr_q_empty", wr_q.size(), 0);
    m_reqtag[2*TW +: TW] = 13'h1002;
    m_req[2*DW +: DW] = 64'hA000_0002;

    // All masters request continuously: strict rotation.
    m_reqcyc = 3'b111;
    for (int r = 0; r < 6; r++) own_q.push_back(2'(r % 3));
    repeat (6) do_read(-1);
    m_reqcyc = 3'b000;
    chk("rr_q_empty", own_q.size(), 0);

    // Reset during beat 4 of a read, then a fresh grant.
    m_reqcyc = 3'b001;
    own_q.push_back(2'd0);
    do_read(4);
    reset = 1'b1;
    m_reqcyc = 3'b010;
    bus_respcyc = 1'b1;
    bus_resp = 64'hDEAD_BEEF;
    #1;
    chk("abort_idle", {busy, owner, bus_respack, m_respcyc, m_resp}, 0);
    own_q.push_back(2'd1);
    do_read(-1);
    m_reqcyc = 3'b000;
    step();
    chk("final_idle", {busy, bus_reqcyc, bus_respack, err_timeout}, 0);
    chk("resp_q_empty", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
